// File: rtl/dht11_read_ctrl_if.sv
// Handshake/data bundle between a DHT11 read controller and its requester/sensor side.
// slave = controller view, master = requester/line side view.
interface dht11_read_ctrl_if;
  logic        tick_1us;
  logic        start;
  logic        dht_in;
  logic        dht_oe;
  logic        busy;
  logic        valid;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] humidity;
  logic [15:0] temperature;

  modport master (
    output tick_1us, start, dht_in,
    input  dht_oe, busy, valid, error, err_code, humidity, temperature
  );

  modport slave (
    input  tick_1us, start, dht_in,
    output dht_oe, busy, valid, error, err_code, humidity, temperature
  );
endinterface

// File: rtl/dht11_read_ctrl.sv
// DHT11 single-read sequencer: start pulse, response check, 40-bit pulse-width capture; DHT_CHECKSUM_EN enables checksum reject.
// Latency: START_LOW_US plus the sensor frame; valid/error pulse one cycle after CHECK or a wait timeout.
// Backpressure: none; start is accepted only in IDLE and ignored while busy.
module dht11_read_ctrl #(
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 40
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  dht11_read_ctrl_if.slave bus
);

  localparam logic [15:0] C_START_LOW = 16'(START_LOW_US);
  localparam logic [15:0] C_TIMEOUT   = 16'(TIMEOUT_US);
  localparam logic [15:0] C_THRESH    = 16'(BIT_THRESH_US);

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next_wait;
  logic        r_sync1, r_sync2, r_line_q;
  logic        w_rise, w_fall, w_edge_hit, w_bit, w_sum_ok;
  logic [15:0] r_us_cnt;
  logic [5:0]  r_bit_cnt;
  logic [39:0] r_data;
  logic        r_dht_oe, r_busy, r_valid, r_error;
  logic [1:0]  r_err_code;
  logic [15:0] r_hum, r_temp;

  // Synchronizer resets high (released line) so reset never fakes an edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_line_q <= 1'b1;
    end else begin
      r_sync1  <= bus.dht_in;
      r_sync2  <= r_sync1;
      r_line_q <= r_sync2;
    end
  end

  // Waits act on transitions, so the stale low left by our own start pulse is not taken as the response.
  assign w_rise = r_sync2 & ~r_line_q;
  assign w_fall = ~r_sync2 & r_line_q;
  assign w_bit  = (r_us_cnt > C_THRESH);

  always_comb begin
    w_edge_hit  = 1'b0;
    w_next_wait = S_IDLE;
    case (r_state)
      S_WAIT_RESP: begin w_edge_hit = w_fall; w_next_wait = S_RESP_LOW;  end
      S_RESP_LOW:  begin w_edge_hit = w_rise; w_next_wait = S_RESP_HIGH; end
      S_RESP_HIGH: begin w_edge_hit = w_fall; w_next_wait = S_BIT_LOW;   end
      S_BIT_LOW:   begin w_edge_hit = w_rise; w_next_wait = S_BIT_HIGH;  end
      S_BIT_HIGH: begin
        w_edge_hit  = w_fall;
        w_next_wait = (r_bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
      end
      default: begin end
    endcase
  end

`ifdef DHT_CHECKSUM_EN
  logic [7:0] w_sum;
  assign w_sum    = r_data[39:32] + r_data[31:24] + r_data[23:16] + r_data[15:8];
  assign w_sum_ok = (w_sum == r_data[7:0]);
`else
  logic w_unused_b4;
  assign w_unused_b4 = ^r_data[7:0];
  assign w_sum_ok    = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_us_cnt   <= 16'd0;
      r_bit_cnt  <= 6'd0;
      r_data     <= 40'd0;
      r_dht_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 2'b00;
      r_hum      <= 16'd0;
      r_temp     <= 16'd0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      // Any state change below overrides this, so a tick on a transition cycle is dropped.
      if (bus.tick_1us && (r_us_cnt != 16'hFFFF))
        r_us_cnt <= r_us_cnt + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_START_LOW;
            r_us_cnt   <= 16'd0;
            r_dht_oe   <= 1'b1;
            r_busy     <= 1'b1;
            r_err_code <= 2'b00;
          end
        end
        S_START_LOW: begin
          if (r_us_cnt >= C_START_LOW) begin
            r_state  <= S_WAIT_RESP;
            r_us_cnt <= 16'd0;
            r_dht_oe <= 1'b0;
          end
        end
        S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH: begin
          if (w_edge_hit) begin
            r_state  <= w_next_wait;
            r_us_cnt <= 16'd0;
            if (r_state == S_RESP_HIGH)
              r_bit_cnt <= 6'd0;
            if (r_state == S_BIT_HIGH) begin
              r_data    <= {r_data[38:0], w_bit};
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end else if (r_us_cnt >= C_TIMEOUT) begin
            r_state    <= S_ERR;
            r_us_cnt   <= 16'd0;
            r_err_code <= 2'b01;
            r_error    <= 1'b1;
          end
        end
        S_CHECK: begin
          r_us_cnt <= 16'd0;
          if (w_sum_ok) begin
            r_state <= S_DONE;
            r_hum   <= r_data[39:24];
            r_temp  <= r_data[23:8];
            r_valid <= 1'b1;
          end else begin
            r_state    <= S_ERR;
            r_err_code <= 2'b10;
            r_error    <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          r_state  <= S_IDLE;
          r_us_cnt <= 16'd0;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_dht_oe <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dht_oe      = r_dht_oe;
  assign bus.busy        = r_busy;
  assign bus.valid       = r_valid;
  assign bus.error       = r_error;
  assign bus.err_code    = r_err_code;
  assign bus.humidity    = r_hum;
  assign bus.temperature = r_temp;

endmodule

// File: tb/tb_dht11_read_ctrl.sv
// Directed bench for dht11_read_ctrl: behavioural DHT11 on an open-drain line, 10-clk microsecond tick.
module tb_dht11_read_ctrl;
  logic clk, rst_n, sens;
  int   n_cmp = 0, n_bad = 0;
  int   n_valid = 0, n_err = 0, n_both = 0;
  int   cyc = 0, err_cyc = 0, rel_cyc = 0, oe_len = 0;
  int   tick_div = 0;
  int   v0, e0;

  dht11_read_ctrl_if ifc();
  assign ifc.dht_in = sens & ~ifc.dht_oe;

  dht11_read_ctrl #(.START_LOW_US(50), .TIMEOUT_US(200), .BIT_THRESH_US(40)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ifc.tick_1us = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ifc.tick_1us = (tick_div == 9);
      tick_div = (tick_div == 9) ? 0 : tick_div + 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifc.valid) n_valid <= n_valid + 1;
    if (ifc.error) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
    if (ifc.valid && ifc.error) n_both <= n_both + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sensor edges land just after a tick-sampling edge, so pulse widths count whole microseconds.
  task automatic wait_us(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (!ifc.tick_1us);
    end
    #1;
  endtask

  task automatic do_start();
    @(posedge clk); #1 ifc.start = 1'b1;
    @(posedge clk); #1 ifc.start = 1'b0;
  endtask

  task automatic sensor_run(input logic [39:0] frame, input int hi0, input int hi1,
                            input bit answer, input int abort_bit, input int poke_bit);
    int   n;
    logic bitv;
    n = 0;
    while (ifc.dht_oe === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    oe_len  = n;
    rel_cyc = cyc;
    if (!answer) return;
    wait_us(10); sens = 1'b0;
    wait_us(20); sens = 1'b1;
    wait_us(20);
    for (int i = 0; i < 40; i++) begin
      bitv = frame[39-i];
      sens = 1'b0;
      if (i == poke_bit) begin
        wait_us(2);
        do_start();
        wait_us(2);
      end else begin
        wait_us(4);
      end
      sens = 1'b1;
      if (i == abort_bit) begin
        wait_us(5);
        rst_n = 1'b0;
        return;
      end
      wait_us(bitv ? hi1 : hi0);
    end
    sens = 1'b0;
    wait_us(5);
    sens = 1'b1;
  endtask

  task automatic wait_evt(input int vb, input int eb);
    int n;
    n = 0;
    while (n_valid == vb && n_err == eb && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check_eq("evt_wait_expired", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; sens = 1'b1; ifc.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dht_oe", ifc.dht_oe, 0);
    check_eq("rst_busy", ifc.busy, 0);
    check_eq("rst_valid", ifc.valid, 0);
    check_eq("rst_error", ifc.error, 0);
    check_eq("rst_err_code", ifc.err_code, 0);
    check_eq("rst_humidity", ifc.humidity, 0);
    check_eq("rst_temperature", ifc.temperature, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Normal read
    v0 = n_valid; e0 = n_err;
    do_start();
    check_eq("t1_oe_after_start", ifc.dht_oe, 1);
    check_eq("t1_busy_after_start", ifc.busy, 1);
    sensor_run(40'h35_00_18_00_4D, 12, 45, 1'b1, -1, -1);
    check_eq("t1_oe_len_50us", (oe_len >= 490 && oe_len <= 510), 1);
    wait_evt(v0, e0);
    check_eq("t1_valid_pulses", n_valid - v0, 1);
    check_eq("t1_error_pulses", n_err - e0, 0);
    check_eq("t1_humidity", ifc.humidity, 16'h3500);
    check_eq("t1_temperature", ifc.temperature, 16'h1800);
    check_eq("t1_err_code", ifc.err_code, 0);
    check_eq("t1_busy_end", ifc.busy, 0);

    // Sensor silent after release
    v0 = n_valid; e0 = n_err;
    do_start();
    sensor_run(40'h0, 12, 45, 1'b0, -1, -1);
    wait_evt(v0, e0);
    check_eq("t2_error_pulses", n_err - e0, 1);
    check_eq("t2_valid_pulses", n_valid - v0, 0);
    check_eq("t2_err_code", ifc.err_code, 2'b01);
    check_eq("t2_timeout_200us", (err_cyc - rel_cyc >= 1985 && err_cyc - rel_cyc <= 2010), 1);
    check_eq("t2_dht_oe", ifc.dht_oe, 0);
    check_eq("t2_busy_end", ifc.busy, 0);
    check_eq("t2_humidity_kept", ifc.humidity, 16'h3500);
    check_eq("t2_temperature_kept", ifc.temperature, 16'h1800);

    // Bad checksum byte
    v0 = n_valid; e0 = n_err;
    do_start();
    sensor_run(40'h36_00_19_00_4E, 12, 45, 1'b1, -1, -1);
    wait_evt(v0, e0);
`ifdef DHT_CHECKSUM_EN
    check_eq("t3_error_pulses", n_err - e0, 1);
    check_eq("t3_valid_pulses", n_valid - v0, 0);
    check_eq("t3_err_code", ifc.err_code, 2'b10);
    check_eq("t3_humidity_kept", ifc.humidity, 16'h3500);
    check_eq("t3_temperature_kept", ifc.temperature, 16'h1800);
`else
    check_eq("t3_valid_pulses", n_valid - v0, 1);
    check_eq("t3_error_pulses", n_err - e0, 0);
    check_eq("t3_err_code", ifc.err_code, 2'b00);
    check_eq("t3_humidity_new", ifc.humidity, 16'h3600);
    check_eq("t3_temperature_new", ifc.temperature, 16'h1900);
`endif

    // Threshold: 40 us high is 0, 41 us is 1; checksum wraps (FF+80+7F+03 = 0x201)
    v0 = n_valid; e0 = n_err;
    do_start();
    sensor_run(40'hFF_80_7F_03_01, 40, 41, 1'b1, -1, -1);
    wait_evt(v0, e0);
    check_eq("t4_valid_pulses", n_valid - v0, 1);
    check_eq("t4_humidity", ifc.humidity, 16'hFF80);
    check_eq("t4_temperature", ifc.temperature, 16'h7F03);
    check_eq("t4_err_code", ifc.err_code, 0);

    // Reset during bit 20 high phase
    v0 = n_valid; e0 = n_err;
    do_start();
    sensor_run(40'h35_00_18_00_4D, 12, 45, 1'b1, 20, -1);
    #1;
    check_eq("t5_oe_in_reset", ifc.dht_oe, 0);
    check_eq("t5_busy_in_reset", ifc.busy, 0);
    check_eq("t5_humidity_reset", ifc.humidity, 0);
    repeat (5) @(negedge clk);
    check_eq("t5_no_pulses", (n_valid - v0) + (n_err - e0), 0);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    v0 = n_valid; e0 = n_err;
    do_start();
    sensor_run(40'h35_00_18_00_4D, 12, 45, 1'b1, -1, -1);
    wait_evt(v0, e0);
    check_eq("t5_reread_valid", n_valid - v0, 1);
    check_eq("t5_reread_humidity", ifc.humidity, 16'h3500);
    check_eq("t5_reread_temperature", ifc.temperature, 16'h1800);

    // start pulsed mid-frame must be ignored
    v0 = n_valid; e0 = n_err;
    do_start();
    sensor_run(40'h50_01_1A_05_70, 12, 45, 1'b1, -1, 5);
    wait_evt(v0, e0);
    repeat (100) @(negedge clk);
    check_eq("t6_valid_pulses", n_valid - v0, 1);
    check_eq("t6_error_pulses", n_err - e0, 0);
    check_eq("t6_humidity", ifc.humidity, 16'h5001);
    check_eq("t6_temperature", ifc.temperature, 16'h1A05);
    check_eq("t6_no_restart_oe", ifc.dht_oe, 0);
    check_eq("t6_no_restart_busy", ifc.busy, 0);

    check_eq("valid_error_overlap", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dht11_read_ctrl.md
# dht11_read_ctrl

Sequencer for one DHT11 1-Wire read transaction. It runs on the system clock and paces every phase with a one-cycle microsecond strobe from the frequency divider. On request it drives the start pulse, checks the sensor response, and captures 40 data bits by pulse-width measurement. It then verifies the checksum and presents humidity and temperature words to the display/UART logic.

## Interface
- START_LOW_US, 18000: start-pulse length in µs (line held low)
- TIMEOUT_US, 200: maximum µs spent in any sensor-wait state
- BIT_THRESH_US, 40: high-phase length above which a bit is 1
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- tick_1us  input  1  one-cycle strobe every 1 µs from the divider
- start  input  1  read request, sampled in IDLE only
- dht_in  input  1  raw data line (asynchronous to clk)
- dht_oe  output  1  1 = pull data line low; 0 = release (pull-up)
- busy  output  1  high from accepted start until DONE/ERR exit
- valid  output  1  one-cycle pulse, new data on humidity/temperature
- error  output  1  one-cycle pulse, transaction aborted
- err_code  output  2  01 timeout, 10 checksum, held until next start
- humidity  output  16  {integer byte, decimal byte}
- temperature  output  16  {integer byte, decimal byte}

## Operation
- dht_in passes through a 2-FF synchronizer; all decisions use the synced value.
- us_cnt (16 bit) clears on every state entry and increments on tick_1us; it saturates at 0xFFFF.
- IDLE: dht_oe=0, busy=0. On start=1, go to START_LOW; err_code clears to 00.
- START_LOW: dht_oe=1. When us_cnt reaches START_LOW_US, go to WAIT_RESP with dht_oe=0.
- WAIT_RESP: wait for synced line low, then go to RESP_LOW.
- RESP_LOW: wait for high, then go to RESP_HIGH.
- RESP_HIGH: wait for low, then go to BIT_LOW. bit_cnt=0.
- BIT_LOW: wait for high, then go to BIT_HIGH.
- BIT_HIGH: wait for low. Shift (us_cnt > BIT_THRESH_US) into the 40-bit register, MSB first. bit_cnt+1. If bit_cnt was 39, go to CHECK; otherwise go to BIT_LOW.
- Every wait state (WAIT_RESP..BIT_HIGH): if us_cnt reaches TIMEOUT_US, go to ERR with err_code=01.
- CHECK:
  - sum = (b0+b1+b2+b3) mod 256, 8-bit wrap.
  - If sum == b4: humidity={b0,b1}, temperature={b2,b3}, go to DONE.
  - Otherwise go to ERR with err_code=10; humidity/temperature stay unchanged.
- DONE: valid=1 for one cycle, then IDLE.
- ERR: error=1 for one cycle, then IDLE.
- start while busy is ignored.

## Timing
- Reset values:
  - dht_oe=0, busy=0, valid=0, error=0, err_code=00, humidity=0x0000, temperature=0x0000.
  - State IDLE; counters and shift register 0.
- Reset asserted mid-transaction releases the line (dht_oe=0) asynchronously and aborts with no valid/error pulse.
- start → dht_oe=1 on the next clk edge. busy rises on the same edge.
- Line-edge detection lags dht_in by 2 clk cycles (synchronizer).
- Pulse-width resolution is ±1 µs. us_cnt == BIT_THRESH_US exactly decodes as 0.
- valid and error are never asserted together. Each asserts exactly 1 cycle after CHECK or the timeout.
- tick_1us and a line edge in the same cycle: the edge wins. The state change clears us_cnt, and that tick is not counted.

## Configuration
- DHT_CHECKSUM_EN defined: CHECK compares sum with b4 as described; a mismatch produces error with err_code=10.
- Not defined:
  - b4 is captured but ignored.
  - CHECK always proceeds to DONE.
  - err_code=10 is never produced.

## Test plan
- Bench settings: START_LOW_US=50, tick_1us every 10 clk. The sensor model sends 0x35 0x00 0x18 0x00 0x4D. Required response: dht_oe low-pulse of 50 µs, then valid pulse with humidity=0x3500, temperature=0x1800, err_code=00, busy falls.
- Sensor model never answers after release → error pulse 200 µs after release, err_code=01, dht_oe=0, outputs unchanged.
- Checksum byte 0x4E with DHT_CHECKSUM_EN → error, err_code=10, humidity stays 0x3500 from the prior run. Without the macro → valid with new data.
- Bit highs of 40 µs and 41 µs → decoded 0 and 1 respectively.
- Reset low during BIT_HIGH (bit 20) → dht_oe=0, busy=0 immediately. The next start completes a normal read.
- start pulsed during BIT_LOW → ignored; a single valid pulse is produced.
